// File: rtl/eightbit_acc_ctrl.sv
// Accumulator controller feeding an 8-bit combinational ALU; one command in flight at a time.
// Accept at edge N, response valid in cycle N+2; res_* held stable while res_ready is low.
module eightbit_acc_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [1:0]       alu_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_f,
    input  logic             alu_ovf,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_ovf,
    output logic             res_err,
    output logic             sticky_ovf,
    output logic [7:0]       cmd_count
);

    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_NOT  = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_OR   = 3'd4;
    localparam logic [2:0] OP_READ = 3'd5;
    localparam logic [2:0] OP_CLR  = 3'd6;
    localparam logic [2:0] OP_ILL  = 3'd7;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state, state_nxt;
    logic             accept, done;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic             ovf_nxt;
    logic             is_alu_op;
    logic [1:0]       sel_nxt;

    assign cmd_ready = (state == IDLE);
    assign res_valid = (state == RESP);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (cmd_valid) begin
                accept    = 1'b1;
                state_nxt = EXEC;
            end
            EXEC: state_nxt = RESP;
            RESP: if (res_ready) begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ALU select decode for the incoming command
    always_comb begin
        is_alu_op = 1'b1;
        sel_nxt   = 2'd0;
        case (cmd_op)
            OP_ADD:  sel_nxt = 2'd0;
            OP_NOT:  sel_nxt = 2'd1;
            OP_AND:  sel_nxt = 2'd2;
            OP_OR:   sel_nxt = 2'd3;
            default: is_alu_op = 1'b0;
        endcase
    end

    // Result of the latched command, evaluated during EXEC
    always_comb begin
        acc_nxt = acc;
        ovf_nxt = 1'b0;
        case (op_q)
            OP_LOAD: acc_nxt = data_q;
            OP_ADD: begin
                acc_nxt = alu_f;
                ovf_nxt = alu_ovf;
            end
            OP_NOT, OP_AND, OP_OR: acc_nxt = alu_f;
            default: acc_nxt = acc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q       <= OP_LOAD;
            data_q     <= '0;
            acc        <= '0;
            alu_sel    <= 2'd0;
            alu_a      <= '0;
            alu_b      <= '0;
            res_data   <= '0;
            res_ovf    <= 1'b0;
            res_err    <= 1'b0;
            sticky_ovf <= 1'b0;
            cmd_count  <= 8'd0;
        end else begin
            if (accept) begin
                op_q   <= cmd_op;
                data_q <= cmd_data;
                if (is_alu_op) begin
                    alu_sel <= sel_nxt;
                    alu_a   <= acc;
                    alu_b   <= cmd_data;
                end
            end
            if (state == EXEC) begin
                acc        <= acc_nxt;
                res_data   <= acc_nxt;
                res_ovf    <= ovf_nxt;
                res_err    <= (op_q == OP_ILL);
                sticky_ovf <= (op_q == OP_CLR) ? 1'b0 : (sticky_ovf | ovf_nxt);
            end
            if (done) cmd_count <= cmd_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_eightbit_acc_ctrl.sv
// Directed-vector bench: driver pushes hand-computed responses, monitor pops on each handshake.
module tb_eightbit_acc_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data;
    logic [1:0] alu_sel;
    logic [7:0] alu_a, alu_b, alu_f;
    logic       alu_ovf;
    logic       res_valid, res_ready;
    logic [7:0] res_data;
    logic       res_ovf, res_err, sticky_ovf;
    logic [7:0] cmd_count;

    always #5 clk = ~clk;

    eightbit_acc_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_ovf(alu_ovf),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_ovf(res_ovf), .res_err(res_err), .sticky_ovf(sticky_ovf), .cmd_count(cmd_count)
    );

    // Downstream ALU stand-in
    always_comb begin
        alu_ovf = 1'b0;
        alu_f   = 8'h00;
        case (alu_sel)
            2'd0: {alu_ovf, alu_f} = {1'b0, alu_a} + {1'b0, alu_b};
            2'd1: alu_f = ~alu_b;
            2'd2: alu_f = alu_a & alu_b;
            default: alu_f = alu_a | alu_b;
        endcase
    end

    typedef struct {
        logic [7:0] data;
        logic       ovf;
        logic       err;
        logic       sticky;
        logic [7:0] cnt;
    } exp_t;

    exp_t       sb[$];
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] sent_cnt = 8'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor samples just before the rising edge, after the driver has settled
    always begin
        exp_t e;
        @(negedge clk);
        #4;
        if (!reset && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_response: got data 0x%0h with empty scoreboard", res_data);
            end else begin
                e = sb.pop_front();
                chk("res_data",   {24'd0, res_data},   {24'd0, e.data});
                chk("res_ovf",    {31'd0, res_ovf},    {31'd0, e.ovf});
                chk("res_err",    {31'd0, res_err},    {31'd0, e.err});
                chk("sticky_ovf", {31'd0, sticky_ovf}, {31'd0, e.sticky});
                chk("cmd_count",  {24'd0, cmd_count},  {24'd0, e.cnt});
            end
        end
    end

    // Issue one command; returns at the falling edge inside EXEC
    task automatic send(input logic [2:0] op, input logic [7:0] d, input logic push,
                        input logic [7:0] ed, input logic eovf, input logic eerr, input logic estk);
        exp_t e;
        int   n;
        if (push) begin
            e.data = ed; e.ovf = eovf; e.err = eerr; e.sticky = estk; e.cnt = sent_cnt;
            sb.push_back(e);
            sent_cnt = sent_cnt + 8'd1;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: cmd_ready=%0b required 1", cmd_ready);
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = 8'hxx;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!(sb.size() == 0 && cmd_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!(sb.size() == 0 && cmd_ready)) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: pending=%0d required 0", sb.size());
        end
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = 8'h00;
        res_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_cmd_ready", {31'd0, cmd_ready},  32'd1);
        chk("rst_res_valid", {31'd0, res_valid},  32'd0);
        chk("rst_res_data",  {24'd0, res_data},   32'd0);
        chk("rst_sticky",    {31'd0, sticky_ovf}, 32'd0);
        chk("rst_count",     {24'd0, cmd_count},  32'd0);
        chk("rst_alu_sel",   {30'd0, alu_sel},    32'd0);
        chk("rst_alu_a",     {24'd0, alu_a},      32'd0);
        chk("rst_alu_b",     {24'd0, alu_b},      32'd0);

        // LOAD then ADD 0
        send(3'd0, 8'h01, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        send(3'd1, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        chk("exec_alu_sel", {30'd0, alu_sel}, 32'd0);
        chk("exec_alu_a",   {24'd0, alu_a},   32'h01);
        chk("exec_alu_b",   {24'd0, alu_b},   32'h00);
        chk("exec_cmd_rdy", {31'd0, cmd_ready}, 32'd0);
        wait_done();
        chk("count_after_2", {24'd0, cmd_count}, 32'd2);

        // Carry out and sticky flag
        send(3'd0, 8'hAB, 1'b1, 8'hAB, 1'b0, 1'b0, 1'b0);
        send(3'd1, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
        send(3'd1, 8'h01, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1);
        send(3'd6, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);

        // Logic ops and READ
        send(3'd0, 8'h55, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        send(3'd3, 8'hAA, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        send(3'd4, 8'hAA, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        send(3'd2, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("not_alu_sel", {30'd0, alu_sel}, 32'd1);
        send(3'd2, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        send(3'd5, 8'h77, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        wait_done();
        chk("count_after_12", {24'd0, cmd_count}, 32'd12);

        // Backpressure: 0xFF + 0x01 wraps with carry
        res_ready = 1'b0;
        send(3'd1, 8'h01, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp_res_valid", {31'd0, res_valid}, 32'd1);
            chk("bp_res_data",  {24'd0, res_data},  32'h00);
            chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            chk("bp_count",     {24'd0, cmd_count}, 32'd12);
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        chk("bp_count_release", {24'd0, cmd_count}, 32'd13);
        chk("bp_idle",          {31'd0, cmd_ready}, 32'd1);

        // Illegal op leaves acc and sticky alone
        send(3'd0, 8'h3C, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1);
        send(3'd7, 8'h99, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b1);
        wait_done();
        chk("count_after_ill", {24'd0, cmd_count}, 32'd15);

        // Reset during EXEC drops the command
        send(3'd0, 8'h10, 1'b1, 8'h10, 1'b0, 1'b0, 1'b1);
        send(3'd1, 8'h05, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        sent_cnt = 8'd0;
        chk("mid_rst_cmd_ready", {31'd0, cmd_ready},  32'd1);
        chk("mid_rst_res_valid", {31'd0, res_valid},  32'd0);
        chk("mid_rst_count",     {24'd0, cmd_count},  32'd0);
        chk("mid_rst_res_data",  {24'd0, res_data},   32'd0);
        chk("mid_rst_sticky",    {31'd0, sticky_ovf}, 32'd0);
        repeat (5) @(negedge clk);
        chk("mid_rst_quiet", {31'd0, res_valid}, 32'd0);
        send(3'd5, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        wait_done();
        chk("count_final", {24'd0, cmd_count}, 32'd1);
        chk("sb_empty",    sb.size(),          32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/eightbit_acc_ctrl.md
Name: eightbit_acc_ctrl

Overview:
Accumulator controller sitting directly upstream of the 8-bit parallel ALU (sel/a/b in, f/ovf out). It accepts commands over a valid/ready handshake and drives the ALU operands from an internal 8-bit accumulator and a registered operand. It captures the ALU result back into the accumulator and returns each result over a second valid/ready handshake. It also keeps a sticky overflow flag and a completed-command counter.

Parameters:
WIDTH, 8, datapath width; must match the ALU (8)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command
cmd_op  input  3  0 LOAD, 1 ADD, 2 NOT, 3 AND, 4 OR, 5 READ, 6 CLRFLAG, 7 illegal
cmd_data  input  WIDTH  operand
alu_sel  output  2  to ALU sel: 0 add, 1 not-b, 2 and, 3 or
alu_a  output  WIDTH  to ALU a (accumulator snapshot)
alu_b  output  WIDTH  to ALU b (operand)
alu_f  input  WIDTH  ALU result
alu_ovf  input  1  ALU carry-out
res_valid  output  1  response present
res_ready  input  1  consumer accepts response
res_data  output  WIDTH  accumulator value after the command
res_ovf  output  1  overflow from this command (ADD only)
res_err  output  1  command was illegal (op 7)
sticky_ovf  output  1  set by any ADD overflow; cleared by CLRFLAG or reset
cmd_count  output  8  completed responses, wraps 255->0

Behaviour:
- FSM states: IDLE, EXEC, RESP. cmd_ready = (state==IDLE); res_valid = (state==RESP). Both are combinational from state.
- Reset (sync, checked first every edge): state=IDLE; acc, alu_sel, alu_a, alu_b, res_data, res_ovf, res_err, sticky_ovf, cmd_count all 0. Reset mid-EXEC or mid-RESP drops the in-flight command, and no response is issued.
- IDLE, cmd_valid&&cmd_ready: latch op and cmd_data; go to EXEC.
  - For ALU ops (ADD/NOT/AND/OR), also register alu_sel = 0/1/2/3, alu_a = acc, alu_b = cmd_data.
  - For other ops, alu_* hold their previous values.
- EXEC (exactly one cycle; the ALU is combinational and settles within it): at the edge, update acc, res_*, and sticky_ovf, then go to RESP.
  - ALU ops: acc = alu_f; res_ovf = alu_ovf if ADD, else 0.
  - LOAD: acc = cmd_data, bypassing the ALU.
  - READ: acc unchanged.
  - CLRFLAG: acc unchanged; sticky_ovf = 0.
  - Illegal op: acc unchanged; res_err = 1.
  - res_err = 0 for all legal ops.
  - res_data = new acc.
  - sticky_ovf |= res_ovf (except for CLRFLAG, which clears it).
- RESP: hold res_* stable while res_valid && !res_ready (indefinite backpressure). On res_ready: cmd_count += 1 (mod 256), go to IDLE.
- Latency: accept at edge N, response visible in cycle N+2. Minimum 3 cycles per command; cmd_ready is low in EXEC and RESP.
- ADD wraps mod 256, with carry reported on res_ovf. NOT ignores acc (result = ~cmd_data). cmd_data, cmd_op, and alu_f are don't-care outside the accept cycle and EXEC respectively.
- A command offered while not ready is not consumed and must be held by the source.

Test Plan:
- Reset, then LOAD 0x01, ADD 0x00 -> responses 0x01/ovf0, then 0x01/ovf0. alu_sel=0, alu_a=0x01, alu_b=0x00 during EXEC. cmd_count=2.
- LOAD 0xAB, ADD 0x55 -> res_data=0x00, res_ovf=1, sticky_ovf=1. ADD 0x01 -> 0x01, ovf0, sticky_ovf stays 1. CLRFLAG -> sticky_ovf=0, res_data=0x01.
- LOAD 0x55, AND 0xAA -> 0x00; OR 0xAA -> 0xAA; NOT 0xFF -> 0x00; NOT 0x00 -> 0xFF; READ -> 0xFF. All with res_ovf=0.
- Backpressure: hold res_ready=0 for 5 cycles after ADD -> res_valid stays 1, res_data stable, cmd_ready=0, cmd_count unchanged. On release, cmd_count increments once.
- Illegal op 7 with acc=0x3C -> res_err=1, res_data=0x3C, sticky_ovf unchanged.
- Assert reset during EXEC of an ADD -> next cycle state IDLE, acc=0, res_valid=0, cmd_count=0, no response ever issued.
